// File: rtl/ntt_pkg.sv
// Shared constants, coefficient type and bit-reversal helper for the NTT output path.
package ntt_pkg;

  localparam int COEFF_W = 12;
  localparam int LOG_N   = 8;

  typedef logic [COEFF_W-1:0] coeff_t;

  // Reverses the low `bits` bits of value; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[5'(bits - 1 - i)] = value[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
module sdp_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ntt_reorder_buf.sv
// Ping-pong reorder buffer: collects bit-reversed NTT frames and replays them in
// natural order over a valid/ready stream, with a 2-entry skid buffer on the output.
module ntt_reorder_buf #(
  parameter int WIDTH = ntt_pkg::COEFF_W,
  parameter int LOG_N = ntt_pkg::LOG_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  import ntt_pkg::*;

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] CNT_MAX = LOG_N'(N - 1);

  logic [1:0]       bank_full_reg;
  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic             drain_bank_reg;
  logic [LOG_N-1:0] wr_cnt_reg;
  logic [LOG_N-1:0] rd_cnt_reg;
  logic             rd_pend_reg;
  logic             rd_pend_last_reg;

  logic [WIDTH-1:0] skid_data_reg [2];
  logic             skid_last_reg [2];
  logic             skid_wptr_reg;
  logic             skid_rptr_reg;
  logic [1:0]       skid_cnt_reg;

  logic             wr_fire;
  logic             rd_fire;
  logic             out_fire;
  logic [1:0]       skid_occ;
  logic [LOG_N-1:0] wr_addr_lo;
  logic [LOG_N:0]   wr_addr;
  logic [LOG_N:0]   rd_addr;
  logic [WIDTH-1:0] ram_rd_data;

  assign in_ready  = !bank_full_reg[wr_bank_reg];
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = (skid_cnt_reg != 2'd0);
  assign out_data  = skid_data_reg[skid_rptr_reg];
  assign out_last  = out_valid && skid_last_reg[skid_rptr_reg];
  assign out_fire  = out_valid && out_ready;

  // An in-flight RAM read already owns a skid slot, so count it as occupied.
  assign skid_occ = skid_cnt_reg + 2'(rd_pend_reg);
  assign rd_fire  = bank_full_reg[rd_bank_reg] && ((skid_occ != 2'd2) || out_fire);

  assign wr_addr_lo = LOG_N'(bitrev(32'(wr_cnt_reg), LOG_N));
  assign wr_addr    = {wr_bank_reg, wr_addr_lo};
  assign rd_addr    = {rd_bank_reg, rd_cnt_reg};

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (2 * N)
  ) u_ram (
    .clk     (clk),
    .we      (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .re      (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_reg    <= 2'b00;
      wr_bank_reg      <= 1'b0;
      rd_bank_reg      <= 1'b0;
      drain_bank_reg   <= 1'b0;
      wr_cnt_reg       <= '0;
      rd_cnt_reg       <= '0;
      rd_pend_reg      <= 1'b0;
      rd_pend_last_reg <= 1'b0;
      skid_wptr_reg    <= 1'b0;
      skid_rptr_reg    <= 1'b0;
      skid_cnt_reg     <= 2'd0;
    end else begin
      if (wr_fire) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
        if (wr_cnt_reg == CNT_MAX) begin
          bank_full_reg[wr_bank_reg] <= 1'b1;
          wr_bank_reg                <= !wr_bank_reg;
        end
      end

      // The writer only targets an empty bank and the drain only clears a full
      // one, so a set and a clear in the same edge always hit different banks.
      if (out_fire && out_last) begin
        bank_full_reg[drain_bank_reg] <= 1'b0;
        drain_bank_reg                <= !drain_bank_reg;
      end

      if (rd_fire) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        if (rd_cnt_reg == CNT_MAX) rd_bank_reg <= !rd_bank_reg;
      end
      rd_pend_reg      <= rd_fire;
      rd_pend_last_reg <= rd_fire && (rd_cnt_reg == CNT_MAX);

      if (rd_pend_reg) skid_wptr_reg <= !skid_wptr_reg;
      if (out_fire)    skid_rptr_reg <= !skid_rptr_reg;
      skid_cnt_reg <= skid_cnt_reg + 2'(rd_pend_reg) - 2'(out_fire);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge clk) begin
      if (rst) begin
        skid_data_reg[gi] <= '0;
        skid_last_reg[gi] <= 1'b0;
      end else if (rd_pend_reg && (skid_wptr_reg == 1'(gi))) begin
        skid_data_reg[gi] <= ram_rd_data;
        skid_last_reg[gi] <= rd_pend_last_reg;
      end
    end
  end

endmodule

// File: tb/tb_ntt_reorder_buf.sv
// Scoreboard bench for ntt_reorder_buf: LOG_N=3 instance for directed scenarios,
// default LOG_N=8 instance for a full-size frame.
module tb_ntt_reorder_buf;

  localparam int W   = 12;
  localparam int LN  = 3;
  localparam int N8  = 256;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic clk;
  logic rst;

  logic         in_valid, in_ready, out_valid, out_last, out_ready;
  logic [W-1:0] in_data, out_data;
  logic         in_valid8, in_ready8, out_valid8, out_last8, out_ready8;
  logic [W-1:0] in_data8, out_data8;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;
  bit t4_done  = 0;

  exp_t exp_q[$];
  exp_t exp8_q[$];
  int   br3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   arr8[N8];
  int   idx8 = 0;
  int   last_idx8 = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ntt_reorder_buf #(.WIDTH(W), .LOG_N(LN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  ntt_reorder_buf dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_data   (in_data8),
    .in_ready  (in_ready8),
    .out_valid (out_valid8),
    .out_data  (out_data8),
    .out_last  (out_last8),
    .out_ready (out_ready8)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int bitrev8(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= (1 << (7 - i));
    return r;
  endfunction

  // Monitor for the LOG_N=3 instance: pops the scoreboard on every output handshake.
  initial begin
    logic         stall_prev;
    logic [W-1:0] pd;
    logic         pl;
    exp_t         e;
    stall_prev = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), int'(pd));
          check("hold_last", int'(out_last), int'(pl));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0d required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            $display("out data=%0d last=%0d exp=%0d/%0d", out_data, out_last, e.data, e.last);
            check("out_data", int'(out_data), int'(e.data));
            check("out_last", int'(out_last), int'(e.last));
          end
        end
        stall_prev = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
      end
    end
  end

  // Monitor for the LOG_N=8 instance; also records outputs by position.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid8 && out_ready8) begin
        if (idx8 < N8) arr8[idx8] = int'(out_data8);
        if (out_last8) last_idx8 = idx8;
        idx8++;
        if (exp8_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output8 actual=%0d required=none", out_data8);
        end else begin
          e = exp8_q.pop_front();
          $display("out8 data=%0d last=%0d exp=%0d/%0d", out_data8, out_last8, e.data, e.last);
          check("out8_data", int'(out_data8), int'(e.data));
          check("out8_last", int'(out_last8), int'(e.last));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = W'(v);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(base + c);
    end
    for (int j = 0; j < 8; j++) begin
      e.data = W'(base + br3[j]);
      e.last = (j == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   run;
    int   t;
    int   idle_bad;
    exp_t e;

    rst = 1'b1;
    in_valid = 1'b0;  in_data = '0;  out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready8", int'(in_ready8), 1);
    check("rst_out_valid8", int'(out_valid8), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single frame and latency from the last input handshake
    send_frame(0, 0);
    check("t1_lat_edge0", int'(out_valid), 0);
    @(negedge clk);
    check("t1_lat_edge1", int'(out_valid), 0);
    @(negedge clk);
    check("t1_lat_edge2", int'(out_valid), 1);
    drain("t1_drain");

    // 2: three back-to-back frames; first two drain without a gap
    fork
      begin
        send_frame(100, 0);
        send_frame(108, 0);
        send_frame(116, 0);
      end
      begin
        t = 0;
        while (!out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        run = 0;
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          if (out_valid) run++;
        end
        check("t2_out_continuous", run, 15);
      end
    join
    drain("t2_drain");

    // 3: full backpressure, both banks fill, then release
    out_ready = 1'b0;
    stalls = 0;
    for (int c = 0; c < 16; c++) send(200 + c);
    check("t3_no_stall_16", stalls, 0);
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 8; j++) begin
        e.data = W'(200 + 8 * f + br3[j]);
        e.last = (j == 7);
        exp_q.push_back(e);
      end
    end
    in_valid = 1'b1;
    in_data  = W'(999);
    check("t3_17th_blocked", int'(in_ready), 0);
    repeat (4) @(negedge clk);
    check("t3_still_blocked", int'(in_ready), 0);
    check("t3_stalled_valid", int'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (!(out_valid && out_last) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t3_last_seen", int'(out_last), 1);
    check("t3_in_ready_before", int'(in_ready), 0);
    @(negedge clk);
    check("t3_in_ready_after", int'(in_ready), 1);
    drain("t3_drain");
    send_frame(300, 0);
    drain("t3_followup");

    // 4: random backpressure and input gaps over 20 frames
    t4_done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) send_frame(1000 + 8 * f, 1);
        t4_done = 1;
      end
      begin
        while (!t4_done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain("t4_drain");

    // 5: reset in the middle of a frame discards it
    for (int c = 0; c < 5; c++) send(500 + c);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) idle_bad++;
    end
    check("t5_idle_after_rst", idle_bad, 0);
    send_frame(600, 0);
    drain("t5_drain");
    repeat (20) @(negedge clk);
    check("t5_no_extra", exp_q.size(), 0);

    // 6: full-size frame on the default instance
    for (int c = 0; c < N8; c++) begin
      e.data = W'(bitrev8(c));
      e.last = (c == N8 - 1);
      exp8_q.push_back(e);
    end
    for (int c = 0; c < N8; c++) begin
      t = 0;
      in_valid8 = 1'b1;
      in_data8  = W'(c);
      while (!in_ready8 && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready8) check("t6_send_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    t = 0;
    while ((exp8_q.size() != 0 || out_valid8) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("t6_drain", exp8_q.size(), 0);
    check("t6_count", idx8, N8);
    check("t6_out1", arr8[1], 128);
    check("t6_out2", arr8[2], 64);
    check("t6_out255", arr8[255], 255);
    check("t6_last_index", last_idx8, N8 - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
